serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 186 ++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity bit and stop bit, sampled mid-bit and presented as a parallel word.
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              en,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    output logic              perr,
    output logic              ferr,
    output logic              busy
);

    localparam int H      = (CLKS_PER_BIT - 1) / 2;
    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TICK_W-1:0] TICK_BIT  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'((H > 0) ? (H - 1) : 0);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam bit                START_AT_T0 = (H == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_reg, state_next;
    logic [TICK_W-1:0]   tick_reg, tick_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                par_reg, par_next;
    logic [DATA_W-1:0]   dout_reg, dout_next;
    logic                dvalid_reg, dvalid_next;
    logic                perr_reg, perr_next;
    logic                ferr_reg, ferr_next;
    logic [DATA_W-1:0]   data_shift;
    logic                sample;

    // Incoming bits enter at the MSB so the first (LSB) bit ends up at bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign data_shift = sin;
        end else begin : g_shift_many
            assign data_shift = {sin, data_reg[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            tick_reg   <= '0;
            bit_reg    <= '0;
            data_reg   <= '0;
            par_reg    <= 1'b0;
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
            perr_reg   <= 1'b0;
            ferr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bit_reg    <= bit_next;
            data_reg   <= data_next;
            par_reg    <= par_next;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
            perr_reg   <= perr_next;
            ferr_reg   <= ferr_next;
        end
    end

    // tick_reg counts down the clocks remaining until the next mid-bit sample.
    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bit_next    = bit_reg;
        data_next   = data_reg;
        par_next    = par_reg;
        dout_next   = dout_reg;
        dvalid_next = 1'b0;
        perr_next   = 1'b0;
        ferr_next   = 1'b0;
        sample      = (tick_reg == '0);

        if (state_reg != S_IDLE && !en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (en && !sin) begin
                        bit_next = '0;
                        par_next = 1'b0;
                        if (START_AT_T0) begin
                            state_next = S_DATA;
                            tick_next  = TICK_BIT;
                        end else begin
                            state_next = S_START;
                            tick_next  = TICK_HALF;
                        end
                    end
                end
                S_START: begin
                    if (sample) begin
                        if (sin) begin
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_DATA;
                            tick_next  = TICK_BIT;
                        end
                    end else begin
                        tick_next = tick_reg - TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        data_next = data_shift;
                        tick_next = TICK_BIT;
                        if (bit_reg == LAST_BIT) begin
                            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_next = bit_reg + BIT_W'(1);
                        end
                    end else begin
                        tick_next = tick_reg - TICK_W'(1);
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        par_next   = (^data_reg) ^ sin;
                        state_next = S_STOP;
                        tick_next  = TICK_BIT;
                    end else begin
                        tick_next = tick_reg - TICK_W'(1);
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        dout_next   = data_reg;
                        dvalid_next = 1'b1;
                        perr_next   = (PARITY_EN != 0) ? par_reg : 1'b0;
                        ferr_next   = !sin;
                        state_next  = sin ? S_IDLE : S_BREAK;
                    end else begin
                        tick_next = tick_reg - TICK_W'(1);
                    end
                end
                S_BREAK: begin
                    if (sin) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // With H=0 the start sample is taken in IDLE, so busy must cover that cycle.
    always_comb begin
        busy = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_START, S_DATA, S_PARITY, S_STOP: busy = 1'b1;
                S_IDLE: busy = START_AT_T0 && en && !sin;
                default: busy = 1'b0;
            endcase
        end
    end

    assign dout   = dout_reg;
    assign dvalid = dvalid_reg;
    assign perr   = perr_reg;
    assign ferr   = ferr_reg;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: one instance at 1 clock/bit, one at 4 clocks/bit,
// checked every cycle against a sample-time model plus literal expectations.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst_f = 1'b0, sin_f = 1'b1, en_f = 1'b1;
    logic       rst_s = 1'b0, sin_s = 1'b1, en_s = 1'b1;
    logic [7:0] dout_f, dout_s;
    logic       dvalid_f, perr_f, ferr_f, busy_f;
    logic       dvalid_s, perr_s, ferr_s, busy_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_fast (
        .clk(clk), .rst(rst_f), .sin(sin_f), .en(en_f), .dout(dout_f),
        .dvalid(dvalid_f), .perr(perr_f), .ferr(ferr_f), .busy(busy_f)
    );

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_slow (
        .clk(clk), .rst(rst_s), .sin(sin_s), .en(en_s), .dout(dout_s),
        .dvalid(dvalid_s), .perr(perr_s), .ferr(ferr_s), .busy(busy_s)
    );

    // Model: mode 0 idle, 1 in frame (anchored at t0), 2 waiting for line high.
    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] t0;
        logic [7:0]  word;
        logic        par;
        logic [7:0]  dout;
        logic        dvalid;
        logic        perr;
        logic        ferr;
    } mdl_t;

    localparam mdl_t MDL0 = '0;

    mdl_t m_f = MDL0;
    mdl_t m_s = MDL0;

    // Outputs after the edge that ends cycle n; bit k is sampled at cnt = k*cpb + h.
    function automatic mdl_t step(input mdl_t m, input int n, input logic s, input logic e, input int cpb);
        int h, cnt, k;
        h = (cpb - 1) / 2;
        m.dvalid = 1'b0;
        m.perr   = 1'b0;
        m.ferr   = 1'b0;
        if (m.mode == 2'd2) begin
            if (!e || s) m.mode = 2'd0;
            return m;
        end
        if (m.mode == 2'd0 && e && !s) begin
            m.mode = 2'd1;
            m.t0   = n;
        end
        if (m.mode == 2'd1) begin
            cnt = n - int'(m.t0);
            if (!e) begin
                m.mode = 2'd0;
            end else if (cnt % cpb == h) begin
                k = cnt / cpb;
                if (k == 0) begin
                    if (s) m.mode = 2'd0;
                end else if (k <= 8) begin
                    m.word[k-1] = s;
                end else if (k == 9) begin
                    m.par = s;
                end else begin
                    m.dvalid = 1'b1;
                    m.dout   = m.word;
                    m.perr   = (^m.word) ^ m.par;
                    m.ferr   = !s;
                    m.mode   = s ? 2'd0 : 2'd2;
                end
            end
        end
        return m;
    endfunction

    function automatic logic exp_busy(input mdl_t m, input logic s, input logic e, input int cpb);
        return (m.mode == 2'd1) || (m.mode == 2'd0 && e && !s && ((cpb - 1) / 2 == 0));
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_dut(input string tag, input logic r, input mdl_t m, input logic s,
                               input logic e, input int cpb, input logic [7:0] d, input logic v,
                               input logic pe, input logic fe, input logic b);
        mdl_t x;
        logic xb;
        x  = r ? MDL0 : m;
        xb = r ? 1'b0 : exp_busy(m, s, e, cpb);
        check_byte({tag, ".dout"}, d, x.dout);
        check_bit({tag, ".dvalid"}, v, x.dvalid);
        check_bit({tag, ".perr"}, pe, x.perr);
        check_bit({tag, ".ferr"}, fe, x.ferr);
        check_bit({tag, ".busy"}, b, xb);
    endtask

    // Model advance and cycle count on the active edge.
    initial forever begin
        @(posedge clk);
        m_f = rst_f ? MDL0 : step(m_f, cyc, sin_f, en_f, 1);
        m_s = rst_s ? MDL0 : step(m_s, cyc, sin_s, en_s, 4);
        cyc++;
    end

    int         fv_cyc[$];
    logic [7:0] fv_dout[$];
    logic       fv_perr[$];
    logic       fv_ferr[$];
    int         sv_cyc[$];
    logic [7:0] sv_dout[$];
    logic       sv_perr[$];
    logic       sv_ferr[$];
    int         fbusy_n = 0, fbusy_first = -1, sbusy_n = 0, sbusy_first = -1;
    logic       fbusy_prev = 1'b0, sbusy_prev = 1'b0;

    // Compare process: every cycle, mid-cycle, both instances.
    initial forever begin
        @(negedge clk);
        compare_dut("fast", rst_f, m_f, sin_f, en_f, 1, dout_f, dvalid_f, perr_f, ferr_f, busy_f);
        compare_dut("slow", rst_s, m_s, sin_s, en_s, 4, dout_s, dvalid_s, perr_s, ferr_s, busy_s);
        if (dvalid_f === 1'b1) begin
            fv_cyc.push_back(cyc);
            fv_dout.push_back(dout_f);
            fv_perr.push_back(perr_f);
            fv_ferr.push_back(ferr_f);
        end
        if (dvalid_s === 1'b1) begin
            sv_cyc.push_back(cyc);
            sv_dout.push_back(dout_s);
            sv_perr.push_back(perr_s);
            sv_ferr.push_back(ferr_s);
        end
        if (busy_f === 1'b1) begin
            fbusy_n++;
            if (!fbusy_prev) fbusy_first = cyc;
        end
        if (busy_s === 1'b1) begin
            sbusy_n++;
            if (!sbusy_prev) sbusy_first = cyc;
        end
        fbusy_prev = (busy_f === 1'b1);
        sbusy_prev = (busy_s === 1'b1);
    end

    task automatic fbit(input logic b);
        sin_f = b;
        @(posedge clk);
        #1;
    endtask

    task automatic fidle(input int n);
        repeat (n) fbit(1'b1);
    endtask

    task automatic fframe(input logic [7:0] w, input logic flip, input logic stop, output int t0);
        t0 = cyc;
        fbit(1'b0);
        for (int i = 0; i < 8; i++) fbit(w[i]);
        fbit((^w) ^ flip);
        fbit(stop);
    endtask

    task automatic sbit(input logic b, input int n);
        sin_s = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sframe(input logic [7:0] w, output int t0);
        t0 = cyc;
        sbit(1'b0, 4);
        for (int i = 0; i < 8; i++) sbit(w[i], 4);
        sbit(^w, 4);
        sbit(1'b1, 4);
    endtask

    task automatic expect_frame_f(input string name, input int base, input int exp_cyc,
                                  input logic [7:0] exp_d, input logic exp_pe, input logic exp_fe);
        int n;
        n = fv_cyc.size();
        check_int({name, ".count"}, n - base, 1);
        if (n > base) begin
            check_int({name, ".cycle"}, fv_cyc[n-1], exp_cyc);
            check_byte({name, ".dout"}, fv_dout[n-1], exp_d);
            check_bit({name, ".perr"}, fv_perr[n-1], exp_pe);
            check_bit({name, ".ferr"}, fv_ferr[n-1], exp_fe);
        end
    endtask

    initial begin
        int t0, t1, base, bb, n;
        logic [7:0] w;

        #1;
        rst_f = 1'b1;
        rst_s = 1'b1;
        @(negedge clk);
        check_byte("reset.dout", dout_f, 8'h00);
        check_bit("reset.dvalid", dvalid_f, 1'b0);
        check_bit("reset.perr", perr_f, 1'b0);
        check_bit("reset.ferr", ferr_f, 1'b0);
        check_bit("reset.busy", busy_f, 1'b0);
        check_byte("reset.slow_dout", dout_s, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_f = 1'b0;
        rst_s = 1'b0;
        fidle(3);

        // Good 0xA5 frame, correct parity
        base = fv_cyc.size();
        bb   = fbusy_n;
        fframe(8'hA5, 1'b0, 1'b1, t0);
        fidle(3);
        expect_frame_f("a5_good", base, t0 + 11, 8'hA5, 1'b0, 1'b0);
        check_int("a5_good.busy_first", fbusy_first, t0);
        check_int("a5_good.busy_cycles", fbusy_n - bb, 11);

        // Same frame with the parity bit inverted
        base = fv_cyc.size();
        fframe(8'hA5, 1'b1, 1'b1, t0);
        fidle(3);
        expect_frame_f("a5_badpar", base, t0 + 11, 8'hA5, 1'b1, 1'b0);

        // 0x3C with stop bit low, line held low, then a normal frame
        base = fv_cyc.size();
        bb   = fbusy_n;
        fframe(8'h3C, 1'b0, 1'b0, t0);
        repeat (5) fbit(1'b0);
        fidle(3);
        expect_frame_f("break_3c", base, t0 + 11, 8'h3C, 1'b0, 1'b1);
        check_int("break_3c.busy_cycles", fbusy_n - bb, 11);
        base = fv_cyc.size();
        fframe(8'h96, 1'b0, 1'b1, t0);
        fidle(3);
        expect_frame_f("after_break", base, t0 + 11, 8'h96, 1'b0, 1'b0);

        // Back-to-back 0x55 then 0xF0 with no idle cycle
        base = fv_cyc.size();
        fframe(8'h55, 1'b0, 1'b1, t0);
        fframe(8'hF0, 1'b0, 1'b1, t1);
        fidle(3);
        n = fv_cyc.size();
        check_int("b2b.count", n - base, 2);
        if (n >= base + 2) begin
            check_int("b2b.spacing", fv_cyc[n-1] - fv_cyc[n-2], 11);
            check_int("b2b.first_cycle", fv_cyc[n-2], t0 + 11);
            check_byte("b2b.first_dout", fv_dout[n-2], 8'h55);
            check_byte("b2b.second_dout", fv_dout[n-1], 8'hF0);
            check_bit("b2b.errs", fv_perr[n-2] | fv_ferr[n-2] | fv_perr[n-1] | fv_ferr[n-1], 1'b0);
        end

        // en dropped at cnt=5
        base = fv_cyc.size();
        bb   = fbusy_n;
        w    = 8'hA5;
        t0   = cyc;
        fbit(1'b0);
        for (int i = 0; i < 4; i++) fbit(w[i]);
        en_f = 1'b0;
        fbit(w[4]);
        en_f  = 1'b1;
        sin_f = 1'b1;
        @(negedge clk);
        check_bit("abort.busy_next", busy_f, 1'b0);
        @(posedge clk);
        #1;
        fidle(5);
        check_int("abort.count", fv_cyc.size() - base, 0);
        check_byte("abort.dout_kept", dout_f, 8'hF0);
        check_int("abort.busy_cycles", fbusy_n - bb, 6);
        base = fv_cyc.size();
        fframe(8'hA5, 1'b0, 1'b1, t0);
        fidle(3);
        expect_frame_f("after_abort", base, t0 + 11, 8'hA5, 1'b0, 1'b0);

        // Reset pulsed mid-frame
        base = fv_cyc.size();
        w    = 8'h0F;
        fbit(1'b0);
        for (int i = 0; i < 3; i++) fbit(w[i]);
        rst_f = 1'b1;
        @(negedge clk);
        check_byte("midrst.dout", dout_f, 8'h00);
        check_bit("midrst.dvalid", dvalid_f, 1'b0);
        check_bit("midrst.perr", perr_f, 1'b0);
        check_bit("midrst.ferr", ferr_f, 1'b0);
        check_bit("midrst.busy", busy_f, 1'b0);
        @(posedge clk);
        #1;
        rst_f = 1'b0;
        fidle(3);
        check_int("midrst.count", fv_cyc.size() - base, 0);
        fframe(8'hA5, 1'b0, 1'b1, t0);
        fidle(3);
        expect_frame_f("after_rst", base, t0 + 11, 8'hA5, 1'b0, 1'b0);

        // 4 clocks/bit: one-cycle glitch, then a full 0x81 frame
        base = sv_cyc.size();
        bb   = sbusy_n;
        t0   = cyc;
        sbit(1'b0, 1);
        sbit(1'b1, 10);
        check_int("glitch.busy_cycles", sbusy_n - bb, 1);
        check_int("glitch.busy_first", sbusy_first, t0 + 1);
        check_int("glitch.count", sv_cyc.size() - base, 0);
        sframe(8'h81, t0);
        sbit(1'b1, 8);
        n = sv_cyc.size();
        check_int("slow_81.count", n - base, 1);
        if (n > base) begin
            check_int("slow_81.cycle", sv_cyc[n-1], t0 + 42);
            check_byte("slow_81.dout", sv_dout[n-1], 8'h81);
            check_bit("slow_81.errs", sv_perr[n-1] | sv_ferr[n-1], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
